// File: rtl/feat_mem_pkg.sv
// Shared definitions for the feature-memory writer.
// Mode encodings, FSM states and the address-width helper.
package feat_mem_pkg;

    localparam logic [1:0] MODE_CONST  = 2'b00;
    localparam logic [1:0] MODE_INCR   = 2'b01;
    localparam logic [1:0] MODE_STREAM = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_STREAM,
        ST_DONE
    } state_e;

    function automatic int calc_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/feat_mem_bram.sv
// Simple dual-port feature BRAM: port A writes, port B reads.
// Port B is registered and read-first; indices >= DEPTH read as 0.
module feat_mem_bram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_W-1:0]     addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic [ADDR_W-1:0]     addrb,
    output logic [DATA_WIDTH-1:0] doutb
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // write port: contents survive reset
    always_ff @(posedge clk) begin
        if (ena && wea) begin
            mem[addra] <= dina;
        end
    end

    // read port: old word on a same-cycle collision, 0 out of range
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            doutb <= '0;
        end else if ({1'b0, addrb} < DEPTH_C) begin
            doutb <= mem[addrb];
        end else begin
            doutb <= '0;
        end
    end

endmodule

// File: rtl/feat_mem_writer.sv
// Feature-memory writer: constant, incrementing or streamed fill.
// Optional FEAT_MEM_AUTOSTART_EN issues one constant fill after reset.
module feat_mem_writer
    import feat_mem_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int NUM_FEATURE_OUT = 16,
    parameter int NUM_SUBGRAPHS   = 2708,
    parameter int DEPTH           = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int ADDR_W          = calc_addr_w(DEPTH),
    parameter int FILL_VALUE      = 50
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W:0]       wr_count,
    input  logic [ADDR_W+1:0]     feat_bram_addrb,
    output logic [DATA_WIDTH-1:0] feat_bram_dout
);

    localparam logic [ADDR_W-1:0]     LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]       DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] FILL_W  = DATA_WIDTH'(FILL_VALUE);

    state_e                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [DATA_WIDTH-1:0] seed_q, seed_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [ADDR_W:0]       cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  start_eff;
    logic [1:0]            start_mode;
    logic                  unused_byte_sel;

`ifdef FEAT_MEM_AUTOSTART_EN
    logic boot_q;

    // one-shot bring-up request on the first clock out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            boot_q <= 1'b1;
        end else begin
            boot_q <= 1'b0;
        end
    end

    assign start_eff  = start | boot_q;
    assign start_mode = boot_q ? MODE_CONST : mode;
`else
    assign start_eff  = start;
    assign start_mode = mode;
`endif

    // control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_CONST;
            seed_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            seed_q  <= seed_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // next state, write strobe and write data
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        seed_d  = seed_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        wr_en   = 1'b0;
        wr_data = '0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_eff) begin
                    mode_d  = (start_mode == 2'b11) ? MODE_CONST : start_mode;
                    seed_d  = seed;
                    addr_d  = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    state_d = (start_mode == MODE_STREAM) ? ST_STREAM : ST_FILL;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                wr_en   = 1'b1;
                wr_data = (mode_q == MODE_INCR)
                        ? seed_q + DATA_WIDTH'(addr_q)
                        : FILL_W;
            end
            ST_STREAM: begin
                wr_en   = s_valid;
                wr_data = s_data;
            end
            default: state_d = ST_IDLE;
        endcase
        if (wr_en) begin
            addr_d = addr_q + 1'b1;
            cnt_d  = (cnt_q == DEPTH_C) ? cnt_q : cnt_q + 1'b1;
            if (addr_q == LAST) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
        end
    end

    assign s_ready  = (state_q == ST_STREAM);
    assign busy     = (state_q == ST_FILL) || (state_q == ST_STREAM);
    assign done     = done_q;
    assign wr_count = cnt_q;

    assign unused_byte_sel = ^feat_bram_addrb[1:0];

    feat_mem_bram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_bram (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (wr_en),
        .wea   (wr_en),
        .addra (addr_q),
        .dina  (wr_data),
        .addrb (feat_bram_addrb[ADDR_W+1:2]),
        .doutb (feat_bram_dout)
    );

endmodule

// File: tb/tb_feat_mem_writer.sv
// Scoreboard bench for feat_mem_writer with a 16-word memory.
// ADDR_W is widened by one so the host port can express word 16.
module tb_feat_mem_writer;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [DW-1:0] seed = '0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready;
    logic          busy;
    logic          done;
    logic [AW:0]   wr_count;
    logic [AW+1:0] addrb = '0;
    logic [DW-1:0] dout;

    always #5 clk = ~clk;

    feat_mem_writer #(
        .DATA_WIDTH      (DW),
        .NUM_FEATURE_OUT (4),
        .NUM_SUBGRAPHS   (4),
        .ADDR_W          (AW),
        .FILL_VALUE      (50)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .mode            (mode),
        .seed            (seed),
        .s_valid         (s_valid),
        .s_data          (s_data),
        .s_ready         (s_ready),
        .busy            (busy),
        .done            (done),
        .wr_count        (wr_count),
        .feat_bram_addrb (addrb),
        .feat_bram_dout  (dout)
    );

    int checks = 0;
    int errors = 0;
    int ref_mem [DEPTH];
    int strm [DEPTH];

    typedef struct {
        int addr;
        int val;
    } rd_t;

    rd_t  exp_q [$];
    logic rd_en = 1'b0;
    logic rd_pipe;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_pipe <= 1'b0;
        else        rd_pipe <= rd_en;
    end

    always @(negedge clk) begin
        if (rd_pipe) begin
            rd_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got %0d expected none", dout);
            end else begin
                e = exp_q.pop_front();
                if (int'(dout) != e.val) begin
                    errors++;
                    $display("FAIL rd_data byte_addr=0x%0h: got %0d expected %0d",
                             e.addr, dout, e.val);
                end
            end
        end
    end

    task automatic rd(input int byte_addr, input int expv);
        rd_t e;
        e.addr = byte_addr;
        e.val  = expv;
        addrb  = (AW+2)'(byte_addr);
        rd_en  = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic rd_word(input int i);
        rd(i * 4 + int'($urandom_range(0, 3)), ref_mem[i]);
    endtask

    task automatic rd_all();
        for (int i = 0; i < DEPTH; i++) rd_word(i);
    endtask

    task automatic start_pass(input logic [1:0] md, input logic [7:0] sd);
        start = 1'b1;
        mode  = md;
        seed  = sd;
        @(negedge clk);
        start = 1'b0;
        mode  = $urandom_range(0, 3);
        seed  = $urandom_range(0, 255);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic fill_ref(input logic [1:0] md, input logic [7:0] sd);
        for (int i = 0; i < DEPTH; i++)
            ref_mem[i] = (md == 2'b01) ? (int'(sd) + i) % 256 : 50;
    endtask

    task automatic end_checks(input string nm);
        chk({nm, "_done"}, int'(done), 1);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_sready"}, int'(s_ready), 0);
        chk({nm, "_wrcnt"}, int'(wr_count), DEPTH);
    endtask

    task automatic after_reset();
        int n;
`ifdef FEAT_MEM_AUTOSTART_EN
        @(negedge clk);
        chk("autostart_busy", int'(busy), 1);
        wait_done(n);
        chk("autostart_cycles", n, 16);
        fill_ref(2'b00, 8'h00);
`else
        @(negedge clk);
        @(negedge clk);
        chk("idle_after_reset", int'(busy), 0);
        n = 0;
`endif
    endtask

    task automatic stream_pass(input bit rnd, input string nm);
        int   hs;
        int   cyc;
        logic v;
        chk({nm, "_sready_pre"}, int'(s_ready), 0);
        start_pass(2'b10, 8'h00);
        hs  = 0;
        cyc = 0;
        while (hs < DEPTH && cyc < 300) begin
            chk({nm, "_done_early"}, int'(done), 0);
            v = rnd ? ($urandom_range(0, 3) != 0) : (cyc % 3 != 2);
            s_valid = v;
            s_data  = strm[hs][DW-1:0];
            if (v && s_ready) hs++;
            cyc++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk({nm, "_handshakes"}, hs, DEPTH);
        end_checks(nm);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = strm[i];
    endtask

    initial begin
        int n;
        logic [1:0] md;
        logic [7:0] sd;

        repeat (3) @(negedge clk);
        chk("rst_sready", int'(s_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wrcnt", int'(wr_count), 0);
        chk("rst_dout", int'(dout), 0);
        rst_n = 1'b1;
        after_reset();

        start_pass(2'b00, 8'h00);
        wait_done(n);
        chk("const_busy_cycles", n, 16);
        end_checks("const");
        fill_ref(2'b00, 8'h00);
        rd_all();

        start_pass(2'b01, 8'd250);
        wait_done(n);
        chk("incr_busy_cycles", n, 16);
        end_checks("incr");
        fill_ref(2'b01, 8'd250);
        rd_all();

        s_valid = 1'b1;
        s_data  = 8'hEE;
        repeat (3) begin
            chk("drop_sready", int'(s_ready), 0);
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("drop_busy", int'(busy), 0);
        rd_word(0);
        rd_word(1);

        for (int i = 0; i < DEPTH; i++) strm[i] = 'hA0 + i;
        stream_pass(1'b0, "strm");
        rd_all();

        start_pass(2'b00, 8'h00);
        repeat (4) @(negedge clk);
        start = 1'b1;
        mode  = 2'b01;
        seed  = 8'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("restart_remaining", n, 11);
        end_checks("restart");
        fill_ref(2'b00, 8'h00);
        rd_all();

        start_pass(2'b01, 8'h00);
        chk("done_cleared", int'(done), 0);
        chk("wrcnt_cleared", int'(wr_count), 0);
        repeat (4) @(negedge clk);
        rd(16, ref_mem[4]);
        wait_done(n);
        chk("incr0_remaining", n, 11);
        end_checks("incr0");
        fill_ref(2'b01, 8'h00);
        rd_all();
        repeat (2) @(negedge clk);

        start_pass(2'b00, 8'h00);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_sready", int'(s_ready), 0);
        chk("mid_rst_wrcnt", int'(wr_count), 0);
        chk("mid_rst_dout", int'(dout), 0);
        for (int i = 0; i < 8; i++) ref_mem[i] = 50;
        @(negedge clk);
        rst_n = 1'b1;
        after_reset();
        rd_word(3);
        rd_word(10);

        rd('h43, 0);
        rd('h7C, 0);
        rd(4 * 15 + 3, ref_mem[15]);

        repeat (5) begin
            md = $urandom_range(0, 3);
            sd = $urandom_range(0, 255);
            if (md == 2'b10) begin
                for (int i = 0; i < DEPTH; i++) strm[i] = $urandom_range(0, 255);
                stream_pass(1'b1, "rnd_strm");
            end else begin
                start_pass(md, sd);
                wait_done(n);
                chk("rnd_busy_cycles", n, 16);
                end_checks("rnd_fill");
                fill_ref(md, sd);
            end
            repeat (6) rd_word($urandom_range(0, DEPTH - 1));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rd_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/feat_mem_writer.md
# feat_mem_writer

- Parametrised writer for the new-feature BRAM; it replaces the fixed free-running constant fill.
- Owns the feature memory and fills it on command in one of three modes: constant, incrementing pattern, or streamed data from the aggregator.
- Reports progress through busy/done and a write count.
- Exposes a byte-addressed host read port that sits on the register-bank/AXI side of the GAT top level.

## Interface
Parameters:
- DATA_WIDTH, 8, feature word width
- NUM_FEATURE_OUT, 16, features per subgraph
- NUM_SUBGRAPHS, 2708, subgraph count
- DEPTH, NUM_SUBGRAPHS*NUM_FEATURE_OUT, memory words
- ADDR_W, $clog2(DEPTH), word address width
- FILL_VALUE, 50, constant-mode fill word

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a pass
- mode  in  2  00 constant, 01 incrementing, 10 stream, 11 reserved (treated as 00); sampled with start
- seed  in  DATA_WIDTH  base value for incrementing mode; sampled with start
- s_valid  in  1  stream word valid
- s_data  in  DATA_WIDTH  stream word
- s_ready  out  1  writer accepts stream word
- busy  out  1  pass in progress
- done  out  1  sticky pass-complete flag
- wr_count  out  ADDR_W+1  words written in current/last pass
- feat_bram_addrb  in  ADDR_W+2  host byte address; word index = bits [ADDR_W+1:2]
- feat_bram_dout  out  DATA_WIDTH  host read data

## Operation
- FSM states: IDLE, FILL, STREAM, DONE.
  - IDLE: start with mode 00/01/11 goes to FILL; start with mode 10 goes to STREAM.
  - start also clears done and wr_count, latches mode and seed, and zeroes the write address.
- FILL: writes one word per cycle at addr 0..DEPTH-1.
  - Constant mode data = FILL_VALUE.
  - Incrementing mode data = (seed + addr) mod 2^DATA_WIDTH, keeping only the low DATA_WIDTH bits.
- STREAM:
  - s_ready = 1 only in STREAM.
  - A word is written on s_valid && s_ready; the address then advances.
  - Gaps in s_valid are allowed; the address holds during a gap.
- After the write at DEPTH-1 the FSM goes to DONE; DONE goes to IDLE on the next cycle. done stays high until the next accepted start.
- start while busy is ignored; the latched mode and seed are unchanged.
- s_valid outside STREAM is dropped; s_ready = 0 and nothing is written.
- wr_count increments on every write and saturates at DEPTH.
- Reads:
  - The host read is read-first.
  - Reading the address being written in the same cycle returns the old word.
  - An out-of-range word index (>= DEPTH) returns 0.
- Reset mid-pass:
  - FSM goes to IDLE; busy, done, s_ready, wr_count and the address go to 0.
  - Memory contents are not cleared.

## Timing
- Reset values: s_ready 0, busy 0, done 0, wr_count 0, feat_bram_dout 0.
- start is sampled on edge 0. busy rises after edge 0, and the first write (addr 0) occurs at edge 1.
- FILL: last write at edge DEPTH. busy falls and done rises after edge DEPTH, so the pass takes DEPTH+1 cycles from start to done.
- STREAM: done rises the cycle after the DEPTH-th accepted handshake.
- Read latency: data for the address presented at edge N is valid after edge N+1.

## Configuration
- FEAT_MEM_AUTOSTART_EN defined:
  - One internal start is issued in mode 00 on the first clock after rst_n deasserts; this is the bring-up behaviour.
  - External start behaves normally afterwards.
- Not defined: the block stays in IDLE until an external start.

## Structure
- Package feat_mem_pkg holds:
  - mode encoding constants (MODE_CONST, MODE_INCR, MODE_STREAM)
  - the state enum
  - the DEPTH/ADDR_W derivation helper
- The memory is one instance of the existing BRAM sub-module:
  - DATA_WIDTH and DEPTH passed through
  - ena = wea = write strobe
  - addrb driven by the word index
- Control, FSM and data generation stay in this module.

## Test plan
All tests use NUM_FEATURE_OUT=4 and NUM_SUBGRAPHS=4 (DEPTH=16).
- Constant fill: start with mode 00 -> busy high for 16 cycles; done after edge 16; all 16 reads return 50; wr_count = 16.
- Incrementing wrap: seed 250, mode 01 -> addr 5 reads 255, addr 6 reads 0, addr 15 reads 9.
- Stream with gaps: mode 10; push 16 words 0xA0+i with s_valid low every third cycle -> each addr i holds 0xA0+i; done only after the 16th handshake; s_ready is 0 before start and after done.
- Restart/ignore: start again at cycle 5 of a FILL -> ignored, done at edge 16. A later start in mode 01 with seed 0 clears done and gives addr i = i.
- Reset mid-pass: assert rst_n low at cycle 8 of a FILL -> outputs go to 0 immediately; after release, addr 3 still reads 50 (memory not cleared).
- Read edge cases:
  - read addr 4 while it is being written -> old value
  - byte address 0x43 maps to word 16, which is out of range -> reads 0
  - with FEAT_MEM_AUTOSTART_EN defined -> constant fill starts with no external start
